// File: rtl/json5_rtl_pkg.sv
// Shared constants, state encoding and helpers for the JSON5 string writer.
package json5_rtl_pkg;

    localparam logic [7:0] CH_QUOTE_D = 8'h22;  // "
    localparam logic [7:0] CH_QUOTE_S = 8'h27;  // '
    localparam logic [7:0] CH_BSLASH  = 8'h5C;  // backslash
    localparam logic [7:0] CH_U       = 8'h75;  // u
    localparam logic [7:0] CH_ZERO    = 8'h30;  // 0

    // Number of bytes that follow the backslash of an escape.
    localparam logic [2:0] TAIL_LEN_SHORT = 3'd1;
    localparam logic [2:0] TAIL_LEN_UNI   = 3'd5;

    typedef enum logic [2:0] {
        IDLE,
        BODY,
        ESC,
        CLOSE,
        DRAIN
    } state_t;

    // Nibble to uppercase ASCII hex digit.
    function automatic logic [7:0] hex_upper(input logic [3:0] nibble);
        if (nibble < 4'd10) begin
            return CH_ZERO + {4'h0, nibble};
        end
        return 8'h37 + {4'h0, nibble};
    endfunction

endpackage

// File: rtl/json5_escape_class.sv
// Combinational classifier: decides whether a raw byte needs escaping and how.
module json5_escape_class
    import json5_rtl_pkg::*;
(
    input  logic [7:0] data,
    input  logic [7:0] quote,
    output logic       need_esc,
    output logic       is_unicode,
    output logic [7:0] short_char
);

    // Map the byte onto a short escape letter, a \u00HH escape, or pass-through.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        need_esc   = 1'b0;
        is_unicode = 1'b0;
        short_char = 8'h00;
        if (data == quote || data == CH_BSLASH) begin
            need_esc   = 1'b1;
            short_char = data;
        end else begin
            case (data)
                8'h08: begin need_esc = 1'b1; short_char = 8'h62; end  // b
                8'h09: begin need_esc = 1'b1; short_char = 8'h74; end  // t
                8'h0A: begin need_esc = 1'b1; short_char = 8'h6E; end  // n
                8'h0B: begin need_esc = 1'b1; short_char = 8'h76; end  // v
                8'h0C: begin need_esc = 1'b1; short_char = 8'h66; end  // f
                8'h0D: begin need_esc = 1'b1; short_char = 8'h72; end  // r
                default: begin
                    if (data < 8'h20 || data == 8'h7F) begin
                        need_esc   = 1'b1;
                        is_unicode = 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/json5_string_writer.sv
// Streaming JSON5 string-literal serializer: raw bytes in, quoted and
// escaped literal out, one byte per beat through a single registered stage.
module json5_string_writer
    import json5_rtl_pkg::*;
#(
    parameter logic [7:0] QUOTE = CH_QUOTE_D
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_last,
    input  logic       in_empty,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic       busy
);

    state_t     state;
    state_t     next_state;
    logic       slot_free;
    logic       in_fire;
    logic       need_esc;
    logic       is_unicode;
    logic [7:0] short_char;

    // Escape in flight: for \u this holds the raw byte, otherwise the tail letter.
    logic       esc_unicode;
    logic [7:0] esc_char;
    logic       esc_last;
    logic [2:0] tail_idx;
    logic [7:0] tail_byte;
    logic       tail_done;

    assign slot_free = !out_valid || out_ready;
    assign in_fire   = in_valid && in_ready;

    json5_escape_class u_escape_class (
        .data       (in_data),
        .quote      (QUOTE),
        .need_esc   (need_esc),
        .is_unicode (is_unicode),
        .short_char (short_char)
    );

    // Select the tail byte for the current index of the escape sequence.
    always_comb begin
        tail_byte = esc_char;
        if (esc_unicode) begin
            case (tail_idx)
                3'd0:    tail_byte = CH_U;
                3'd1,
                3'd2:    tail_byte = CH_ZERO;
                3'd3:    tail_byte = hex_upper(esc_char[7:4]);
                default: tail_byte = hex_upper(esc_char[3:0]);
            endcase
        end
        tail_done = (tail_idx == (esc_unicode ? TAIL_LEN_UNI - 3'd1 : TAIL_LEN_SHORT - 3'd1));
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (in_valid) next_state = BODY;
            BODY: begin
                if (in_fire) begin
                    if (in_empty)      next_state = CLOSE;
                    else if (need_esc) next_state = ESC;
                    else if (in_last)  next_state = CLOSE;
                end
            end
            ESC:   if (slot_free && tail_done) next_state = esc_last ? CLOSE : BODY;
            CLOSE: if (slot_free) next_state = DRAIN;
            DRAIN: if (out_valid && out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Handshake and status outputs.
    always_comb begin
        in_ready = (state == BODY) && slot_free;
        busy     = (state != IDLE);
    end

    // Output register and escape bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_data    <= 8'h00;
            out_last    <= 1'b0;
            esc_unicode <= 1'b0;
            esc_char    <= 8'h00;
            esc_last    <= 1'b0;
            tail_idx    <= 3'd0;
        end else begin
            // A consumed byte frees the slot unless a new one is loaded below.
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        out_valid <= 1'b1;
                        out_data  <= QUOTE;
                        out_last  <= 1'b0;
                    end
                end
                BODY: begin
                    if (in_fire && !in_empty) begin
                        out_valid <= 1'b1;
                        out_last  <= 1'b0;
                        if (need_esc) begin
                            out_data    <= CH_BSLASH;
                            esc_unicode <= is_unicode;
                            esc_char    <= is_unicode ? in_data : short_char;
                            esc_last    <= in_last;
                            tail_idx    <= 3'd0;
                        end else begin
                            out_data <= in_data;
                        end
                    end
                end
                ESC: begin
                    if (slot_free) begin
                        out_valid <= 1'b1;
                        out_data  <= tail_byte;
                        out_last  <= 1'b0;
                        tail_idx  <= tail_idx + 3'd1;
                    end
                end
                CLOSE: begin
                    if (slot_free) begin
                        out_valid <= 1'b1;
                        out_data  <= QUOTE;
                        out_last  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_json5_string_writer.sv
// Directed bench for json5_string_writer: one instance per delimiter, the
// unused one is held in reset while the other is exercised.
`timescale 1ns/1ps
module tb_json5_string_writer;

    typedef struct {
        logic [7:0] data;
        logic       last;
        int         cyc;
    } cap_t;

    logic       clk;
    logic       a_rst_n, b_rst_n;
    logic       in_valid, in_last, in_empty, out_ready;
    logic [7:0] in_data;
    logic       a_in_ready, a_out_valid, a_out_last, a_busy;
    logic       b_in_ready, b_out_valid, b_out_last, b_busy;
    logic [7:0] a_out_data, b_out_data;
    logic       sel_b, bp_en;

    logic       cur_rst_n, cur_in_ready, cur_out_valid, cur_out_last, cur_busy;
    logic [7:0] cur_out_data;

    int         cycle = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    cap_t       cap_q[$];
    logic [7:0] exp_q[$];
    logic       prev_stall = 1'b0;
    logic [7:0] held_data = 8'h00;
    logic       held_last = 1'b0;

    json5_string_writer #(.QUOTE(8'h22)) dut_a (
        .clk(clk), .rst_n(a_rst_n),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
        .in_last(in_last), .in_empty(in_empty),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
        .out_last(a_out_last), .busy(a_busy)
    );

    json5_string_writer #(.QUOTE(8'h27)) dut_b (
        .clk(clk), .rst_n(b_rst_n),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
        .in_last(in_last), .in_empty(in_empty),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
        .out_last(b_out_last), .busy(b_busy)
    );

    assign cur_rst_n     = sel_b ? b_rst_n     : a_rst_n;
    assign cur_in_ready  = sel_b ? b_in_ready  : a_in_ready;
    assign cur_out_valid = sel_b ? b_out_valid : a_out_valid;
    assign cur_out_data  = sel_b ? b_out_data  : a_out_data;
    assign cur_out_last  = sel_b ? b_out_last  : a_out_last;
    assign cur_busy      = sel_b ? b_busy      : a_busy;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Downstream: always ready unless backpressure is enabled.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor at the falling edge: record handshakes, check stall stability.
    always @(negedge clk) begin
        if (cur_rst_n) begin
            if (prev_stall) begin
                check("stall_valid", cur_out_valid, 1'b1);
                check("stall_data", cur_out_data, held_data);
                check("stall_last", cur_out_last, held_last);
            end
            if (cur_out_valid && out_ready)
                cap_q.push_back('{data: cur_out_data, last: cur_out_last, cyc: cycle});
            prev_stall <= cur_out_valid && !out_ready;
            held_data  <= cur_out_data;
            held_last  <= cur_out_last;
        end else begin
            prev_stall <= 1'b0;
        end
    end

    // Drive one input beat and hold it until accepted; hs returns the accept cycle.
    task automatic send_beat(input logic [7:0] d, input logic last, input logic empty, output int hs);
        int t = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        in_empty = empty;
        @(negedge clk);
        while (!cur_in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!cur_in_ready) check("hs_timeout", 0, 1);
        hs = cycle;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_empty = 1'b0;
    endtask

    // Wait for the writer to return to idle with nothing pending; done = that cycle.
    task automatic wait_done(output int done);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while ((cur_busy || cur_out_valid) && t < 1000);
        if (cur_busy || cur_out_valid) check("done_timeout", 0, 1);
        done = cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic compare(input string tag);
        check($sformatf("%s_len", tag), cap_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            check($sformatf("%s_byte%0d", tag, i), cap_q[i].data, exp_q[i]);
            check($sformatf("%s_last%0d", tag, i), cap_q[i].last, (i == exp_q.size() - 1));
        end
    endtask

    task automatic clear_q();
        cap_q.delete();
        exp_q.delete();
    endtask

    task automatic push_list(input logic [7:0] v[], input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(v[i]);
    endtask

    // Reference escaping of one raw byte for delimiter q.
    task automatic push_model(input logic [7:0] b, input logic [7:0] q);
        string hx = "0123456789ABCDEF";
        string sl = "btnvfr";
        if (b == q || b == 8'h5C) begin
            exp_q.push_back(8'h5C);
            exp_q.push_back(b);
        end else if (b >= 8'h08 && b <= 8'h0D) begin
            exp_q.push_back(8'h5C);
            exp_q.push_back(sl[int'(b) - 8]);
        end else if (b < 8'h20 || b == 8'h7F) begin
            exp_q.push_back(8'h5C);
            exp_q.push_back(8'h75);
            exp_q.push_back(8'h30);
            exp_q.push_back(8'h30);
            exp_q.push_back(hx[int'(b[7:4])]);
            exp_q.push_back(hx[int'(b[3:0])]);
        end else begin
            exp_q.push_back(b);
        end
    endtask

    initial begin
        int h1, h2, h3, done, start;
        logic [7:0] d;
        logic [7:0] specials[4];
        specials = '{8'h22, 8'h5C, 8'h27, 8'h7F};

        in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; in_empty = 1'b0;
        a_rst_n = 1'b0; b_rst_n = 1'b0; sel_b = 1'b0; bp_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        check("rst_a_out_valid", a_out_valid, 1'b0);
        check("rst_a_out_data", a_out_data, 8'h00);
        check("rst_a_out_last", a_out_last, 1'b0);
        check("rst_a_in_ready", a_in_ready, 1'b0);
        check("rst_a_busy", a_busy, 1'b0);
        check("rst_b_out_valid", b_out_valid, 1'b0);
        check("rst_b_busy", b_busy, 1'b0);

        a_rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_in_ready", a_in_ready, 1'b0);

        // "ab": full rate, opening quote one cycle after in_valid.
        clear_q();
        push_list('{8'h22, 8'h61, 8'h62, 8'h22}, 4);
        start = cycle;
        send_beat(8'h61, 1'b0, 1'b0, h1);
        send_beat(8'h62, 1'b1, 1'b0, h2);
        wait_done(done);
        compare("ab");
        if (cap_q.size() == 4) begin
            check("ab_latency", cap_q[0].cyc - start, 1);
            for (int i = 1; i < 4; i++)
                check($sformatf("ab_rate%0d", i), cap_q[i].cyc - cap_q[0].cyc, i);
        end

        // Quote and backslash escapes, one stall cycle each.
        clear_q();
        push_list('{8'h22, 8'h5C, 8'h22, 8'h5C, 8'h5C, 8'h22}, 6);
        send_beat(8'h22, 1'b0, 1'b0, h1);
        send_beat(8'h5C, 1'b1, 1'b0, h2);
        wait_done(done);
        compare("short");
        check("short_stall", h2 - h1, 2);

        // \u escapes with uppercase hex, five stall cycles each.
        clear_q();
        push_list('{8'h22, 8'h5C, 8'h75, 8'h30, 8'h30, 8'h30, 8'h31,
                    8'h5C, 8'h75, 8'h30, 8'h30, 8'h31, 8'h46,
                    8'h5C, 8'h75, 8'h30, 8'h30, 8'h37, 8'h46, 8'h22}, 20);
        send_beat(8'h01, 1'b0, 1'b0, h1);
        send_beat(8'h1F, 1'b0, 1'b0, h2);
        send_beat(8'h7F, 1'b1, 1'b0, h3);
        wait_done(done);
        compare("uni");
        check("uni_stall1", h2 - h1, 6);
        check("uni_stall2", h3 - h2, 6);

        // Empty string.
        clear_q();
        push_list('{8'h22, 8'h22}, 2);
        send_beat(8'h00, 1'b1, 1'b1, h1);
        wait_done(done);
        compare("empty");
        if (cap_q.size() == 2) check("empty_busy_drop", done - cap_q[1].cyc, 1);

        // 64-byte mixed string under random backpressure.
        clear_q();
        exp_q.push_back(8'h22);
        bp_en = 1'b1;
        for (int i = 0; i < 64; i++) begin
            case ($urandom_range(0, 3))
                0:       d = 8'($urandom_range(32, 126));
                1:       d = 8'($urandom_range(0, 31));
                2:       d = specials[$urandom_range(0, 3)];
                default: d = 8'($urandom_range(128, 255));
            endcase
            push_model(d, 8'h22);
            send_beat(d, (i == 63), 1'b0, h1);
        end
        exp_q.push_back(8'h22);
        bp_en = 1'b0;
        wait_done(done);
        compare("rand");

        // Single-quote delimiter instance.
        a_rst_n = 1'b0;
        sel_b   = 1'b1;
        b_rst_n = 1'b1;
        @(posedge clk);
        #1;
        clear_q();
        push_list('{8'h27, 8'h22, 8'h5C, 8'h27, 8'h27}, 5);
        send_beat(8'h22, 1'b0, 1'b0, h1);
        send_beat(8'h27, 1'b1, 1'b0, h2);
        wait_done(done);
        compare("sq");

        // Reset in the middle of a \u escape.
        send_beat(8'h01, 1'b1, 1'b0, h1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("mid_busy_before", b_busy, 1'b1);
        b_rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", b_out_valid, 1'b0);
        check("mid_rst_out_data", b_out_data, 8'h00);
        check("mid_rst_busy", b_busy, 1'b0);
        check("mid_rst_in_ready", b_in_ready, 1'b0);
        @(posedge clk);
        #1;
        b_rst_n = 1'b1;
        @(posedge clk);
        #1;
        clear_q();
        push_list('{8'h27, 8'h41, 8'h27}, 3);
        send_beat(8'h41, 1'b1, 1'b0, h1);
        wait_done(done);
        compare("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/json5_string_writer.md
# json5_string_writer

Streaming JSON5 string-literal serializer: accepts raw string bytes on a valid/ready input stream and emits the quoted, escaped JSON5 literal on a valid/ready output stream, one byte per beat. It is the emit-side counterpart of the string reader/unescaper in the I/O layer and feeds the byte-level writer path, which handles file or string sinks. Throughput is one output byte per cycle. Plain bytes pass through at full rate. Escaped bytes stall the input while the escape sequence is emitted.

## Interface
Parameters:
- QUOTE, 8'h22, delimiter byte; legal values are 8'h22 (") or 8'h27 (').

Ports:
- clk  in  1  clock; all state is updated on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_data  in  8  raw string byte.
- in_last  in  1  final beat of the current string.
- in_empty  in  1  beat carries no byte; only legal together with in_last.
- out_valid  out  1  output byte valid.
- out_ready  in  1  downstream accepts the output byte.
- out_data  out  8  serialized byte.
- out_last  out  1  marks the closing delimiter.
- busy  out  1  high whenever state != IDLE.

## Operation
- The output is a single registered stage: out_valid, out_data and out_last all come from flops.
- A slot is free when !out_valid || out_ready.
- States and transitions:
  - IDLE: in_ready=0. When in_valid is seen, load QUOTE into the output register and go to BODY.
  - BODY: in_ready = slot free. On an input handshake:
    - in_empty=1: go to CLOSE.
    - Byte needs no escape: load the byte; stay in BODY, or go to CLOSE if in_last.
    - Byte needs an escape: load 8'h5C ('\'), latch the escape tail and in_last, go to ESC.
  - ESC: in_ready=0. Emit the remaining tail bytes, one per free slot. After the final tail byte, go to CLOSE if the latched last flag is set, else back to BODY.
  - CLOSE: in_ready=0. When the slot is free, load QUOTE with out_last=1 and go to DRAIN.
  - DRAIN: in_ready=0. Wait for the closing-delimiter handshake, then go to IDLE.
- Escape map, tail bytes only:
  - QUOTE → QUOTE.
  - 5C → 5C.
  - 08 → 'b'.
  - 09 → 't'.
  - 0A → 'n'.
  - 0B → 'v'.
  - 0C → 'f'.
  - 0D → 'r'.
  - Any other byte < 8'h20, and 8'h7F → "u00HH", with uppercase hex digits (5 tail bytes).
  - The non-selected quote character and bytes ≥ 8'h80 pass through unchanged. UTF-8 is not interpreted.
- Tail index counter: 3 bits. Short escapes use a tail length of 1; \u escapes use a tail length of 5.

## Timing
- Reset values: out_valid=0, out_data=8'h00, out_last=0, in_ready=0, busy=0, state=IDLE.
- Reset asserted mid-string discards all partial state immediately. No closing quote is emitted.
- Latency:
  - in_valid seen in IDLE at cycle N → opening QUOTE has out_valid=1 at N+1.
  - The first input beat is not consumed in IDLE; it is accepted in BODY at N+1 or later.
  - Input handshake at cycle M → the first byte of its output is valid at M+1.
- out_data and out_last must hold stable while out_valid && !out_ready.
- A plain-byte stream with out_ready held at 1 sustains one byte per cycle with no bubbles.
- An escape stalls the input for its full tail: 1 cycle for a short escape, 5 cycles for \u, assuming out_ready=1.
- A zero-length string produces two beats, QUOTE then QUOTE with out_last=1.
- No new string starts until the closing delimiter has handshaken.

## Structure
- Shared package json5_rtl_pkg holds:
  - Byte constants: CH_QUOTE_D, CH_QUOTE_S, CH_BSLASH, CH_U.
  - The state enum: IDLE, BODY, ESC, CLOSE, DRAIN.
  - A function hex_upper(nibble) → ASCII byte.
- Sub-module json5_escape_class: combinational. Takes the byte and QUOTE. Outputs need_esc, is_unicode and short_char.

## Test plan
- Plain string "ab" (61, 62+last) with out_ready=1 → 22 61 62 22 on consecutive cycles; out_last only on the final 22.
- Input 22, 5C(last) → 22 5C 22 5C 5C 22; in_ready low for exactly 1 cycle after each escaped byte.
- Input 01, 1F, 7F(last) → 22 5C 75 30 30 30 31 5C 75 30 30 31 46 5C 75 30 30 37 46 22.
- Empty string (in_empty=1, in_last=1) → 22 22 with out_last on the second beat; busy returns to 0 the cycle after the final handshake.
- Random 50% out_ready backpressure on a 64-byte mixed string: output held stable while stalled; byte stream matches a reference model; no drops or duplicates.
- QUOTE=8'h27 with input 22, 27(last) → 27 22 5C 27 27. Then assert rst_n low mid-\u escape → out_valid=0 immediately; the next string serializes correctly from IDLE.
